// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and size decode.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  localparam int unsigned MAX_ACCESS_BYTES = 8;

  // Number of bytes touched by an access of the given size.
  function automatic logic [3:0] size_bytes(input size_e size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: strobes and shifted store data across two beats, plus
// extraction and sign/zero extension of load data from the {hi,lo} beat pair.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off_i,
  input  size_e                     size_i,
  input  logic                      sig_i,
  input  logic [XLEN-1:0]           wdata_i,
  input  logic [XLEN-1:0]           rdata_lo_i,
  input  logic [XLEN-1:0]           rdata_hi_i,
  output logic [XLEN/4-1:0]         strb_o,
  output logic [2*XLEN-1:0]         wdata_o,
  output logic [XLEN-1:0]           rdata_o
);

  localparam int unsigned STRB_W = XLEN / 8;

  logic [3:0]          nbytes;
  logic [2*STRB_W-1:0] mask;
  logic [XLEN-1:0]     field;
  logic                sbit;

  always_comb begin
    nbytes = size_bytes(size_i);
    mask   = '0;
    for (int unsigned i = 0; i < 2 * STRB_W; i++) begin
      mask[i] = (i < 32'(nbytes));
    end
    strb_o  = mask << off_i;
    wdata_o = {{XLEN{1'b0}}, wdata_i} << {off_i, 3'b000};

    // Bring the addressed byte to lane 0, then extend from the access MSB.
    field = XLEN'({rdata_hi_i, rdata_lo_i} >> {off_i, 3'b000});
    sbit  = field[XLEN-1];
    case (size_i)
      SZ_B:    sbit = field[7];
      SZ_H:    sbit = field[15];
      SZ_W:    sbit = field[31];
      default: sbit = field[XLEN-1];
    endcase
    rdata_o = '0;
    for (int unsigned b = 0; b < XLEN; b++) begin
      rdata_o[b] = (b < 8 * 32'(nbytes)) ? field[b] : (sig_i & sbit);
    end
  end

endmodule

// File: rtl/lsu_split.sv
// Sequential load/store unit: valid/ready request in, req/gnt + rvalid bus out,
// with optional splitting of misaligned accesses into two aligned beats.
module lsu_split
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter bit          MISALIGNED_SPLIT = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [XLEN-1:0]   i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_sig,
  output logic              o_rsp_valid,
  output logic [XLEN-1:0]   o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_bus_req,
  output logic [XLEN-1:0]   o_bus_addr,
  output logic              o_bus_we,
  output logic [XLEN-1:0]   o_bus_wdata,
  output logic [XLEN/8-1:0] o_bus_wstrb,
  input  logic              i_bus_gnt,
  input  logic              i_bus_rvalid,
  input  logic [XLEN-1:0]   i_bus_rdata
);

  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  size_e               size_q, size_d;
  logic                sig_q, sig_d;
  logic                split_q, split_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic [XLEN-1:0]     hi_q, hi_d;

  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]     rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                bus_req_q, bus_req_d;
  logic [XLEN-1:0]     bus_addr_q, bus_addr_d;
  logic                bus_we_q, bus_we_d;
  logic [XLEN-1:0]     bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;

  logic [3:0]          req_nbytes_c;
  logic                illegal_c;
  logic                misal_c;
  logic                err_c;
  logic                beat1_c;
  logic [2*STRB_W-1:0] strb_c;
  logic [2*XLEN-1:0]   wdata_sh_c;
  logic [XLEN-1:0]     ldata_c;

  // Decode of the incoming request, used only on acceptance in IDLE.
  always_comb begin
    req_nbytes_c = size_bytes(size_e'(i_req_size));
    illegal_c    = (i_req_size == 2'd3) && (XLEN == 32);
    misal_c      = (i_req_addr[3:0] & (req_nbytes_c - 4'd1)) != 4'd0;
    err_c        = illegal_c || (misal_c && !MISALIGNED_SPLIT);
  end

  // Lane logic runs on next-state values so registered bus/response outputs
  // are correct in the first cycle of each state.
  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .off_i      (addr_d[OFF_W-1:0]),
    .size_i     (size_d),
    .sig_i      (sig_d),
    .wdata_i    (wdata_d),
    .rdata_lo_i (lo_d),
    .rdata_hi_i (hi_d),
    .strb_o     (strb_c),
    .wdata_o    (wdata_sh_c),
    .rdata_o    (ldata_c)
  );

  // Next-state and capture logic.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    sig_d     = sig_q;
    split_d   = split_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    rsp_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid && ready_q) begin
          we_d    = i_req_we;
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          size_d  = size_e'(i_req_size);
          sig_d   = i_req_sig;
          split_d = (32'(i_req_addr[OFF_W-1:0]) + 32'(req_nbytes_c)) > STRB_W;
          lo_d    = '0;
          hi_d    = '0;
          if (err_c) begin
            state_d   = ST_RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d = ST_REQ0;
          end
        end
      end
      ST_REQ0:  if (i_bus_gnt) state_d = ST_WAIT0;
      ST_WAIT0: begin
        if (i_bus_rvalid) begin
          lo_d    = i_bus_rdata;
          state_d = split_q ? ST_REQ1 : ST_RESP;
        end
      end
      ST_REQ1:  if (i_bus_gnt) state_d = ST_WAIT1;
      ST_WAIT1: begin
        if (i_bus_rvalid) begin
          hi_d    = i_bus_rdata;
          state_d = ST_RESP;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output next-values, decoded from the state being entered.
  always_comb begin
    beat1_c     = (state_d == ST_REQ1);
    ready_d     = (state_d == ST_IDLE);
    bus_req_d   = (state_d == ST_REQ0) || (state_d == ST_REQ1);
    bus_addr_d  = '0;
    bus_we_d    = 1'b0;
    bus_wdata_d = '0;
    bus_wstrb_d = '0;
    if (bus_req_d) begin
      bus_addr_d  = {addr_d[XLEN-1:OFF_W], {OFF_W{1'b0}}} + (beat1_c ? XLEN'(STRB_W) : '0);
      bus_we_d    = we_d;
      bus_wdata_d = beat1_c ? wdata_sh_c[2*XLEN-1:XLEN] : wdata_sh_c[XLEN-1:0];
      bus_wstrb_d = beat1_c ? strb_c[2*STRB_W-1:STRB_W] : strb_c[STRB_W-1:0];
    end
    rsp_valid_d = (state_d == ST_RESP);
    rsp_data_d  = (rsp_valid_d && !rsp_err_d && !we_d) ? ldata_c : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= SZ_B;
      sig_q       <= 1'b0;
      split_q     <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      sig_q       <= sig_d;
      split_q     <= split_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      bus_req_q   <= bus_req_d;
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
    end
  end

  assign o_req_ready = ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_bus_req   = bus_req_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_we    = bus_we_q;
  assign o_bus_wdata = bus_wdata_q;
  assign o_bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_lsu_split.sv
// Bench for lsu_split: directed vector table, byte-level reference model with
// random traffic, reset corner cases, plus SPLIT=0 and XLEN=64 instances.
module tb_lsu_split;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance: XLEN=32, split enabled
  logic        req_valid, req_ready, req_we, req_sig;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  lsu_split #(.XLEN(32), .MISALIGNED_SPLIT(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_size(req_size),
    .i_req_sig(req_sig), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
    .o_rsp_err(rsp_err), .o_bus_req(bus_req), .o_bus_addr(bus_addr),
    .o_bus_we(bus_we), .o_bus_wdata(bus_wdata), .o_bus_wstrb(bus_wstrb),
    .i_bus_gnt(bus_gnt), .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata)
  );

  // SPLIT=0 instance
  logic        n_req_valid, n_req_ready, n_req_we, n_req_sig;
  logic [31:0] n_req_addr, n_req_wdata;
  logic [1:0]  n_req_size;
  logic        n_rsp_valid, n_rsp_err;
  logic [31:0] n_rsp_data;
  logic        n_bus_req, n_bus_we, n_bus_gnt, n_bus_rvalid;
  logic [31:0] n_bus_addr, n_bus_wdata, n_bus_rdata;
  logic [3:0]  n_bus_wstrb;

  lsu_split #(.XLEN(32), .MISALIGNED_SPLIT(1'b0)) dut_ns (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(n_req_valid), .o_req_ready(n_req_ready), .i_req_we(n_req_we),
    .i_req_addr(n_req_addr), .i_req_wdata(n_req_wdata), .i_req_size(n_req_size),
    .i_req_sig(n_req_sig), .o_rsp_valid(n_rsp_valid), .o_rsp_data(n_rsp_data),
    .o_rsp_err(n_rsp_err), .o_bus_req(n_bus_req), .o_bus_addr(n_bus_addr),
    .o_bus_we(n_bus_we), .o_bus_wdata(n_bus_wdata), .o_bus_wstrb(n_bus_wstrb),
    .i_bus_gnt(n_bus_gnt), .i_bus_rvalid(n_bus_rvalid), .i_bus_rdata(n_bus_rdata)
  );

  // XLEN=64 instance
  logic        w_req_valid, w_req_ready, w_req_we, w_req_sig;
  logic [63:0] w_req_addr, w_req_wdata;
  logic [1:0]  w_req_size;
  logic        w_rsp_valid, w_rsp_err;
  logic [63:0] w_rsp_data;
  logic        w_bus_req, w_bus_we, w_bus_gnt, w_bus_rvalid;
  logic [63:0] w_bus_addr, w_bus_wdata, w_bus_rdata;
  logic [7:0]  w_bus_wstrb;

  lsu_split #(.XLEN(64), .MISALIGNED_SPLIT(1'b1)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(w_req_valid), .o_req_ready(w_req_ready), .i_req_we(w_req_we),
    .i_req_addr(w_req_addr), .i_req_wdata(w_req_wdata), .i_req_size(w_req_size),
    .i_req_sig(w_req_sig), .o_rsp_valid(w_rsp_valid), .o_rsp_data(w_rsp_data),
    .o_rsp_err(w_rsp_err), .o_bus_req(w_bus_req), .o_bus_addr(w_bus_addr),
    .o_bus_we(w_bus_we), .o_bus_wdata(w_bus_wdata), .o_bus_wstrb(w_bus_wstrb),
    .i_bus_gnt(w_bus_gnt), .i_bus_rvalid(w_bus_rvalid), .i_bus_rdata(w_bus_rdata)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sig;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          nb;
    logic [31:0] a0;
    logic [3:0]  s0;
    logic [31:0] w0;
    logic [31:0] a1;
    logic [3:0]  s1;
    logic [31:0] w1;
    logic [31:0] data;
    logic        err;
  } vec_t;

  // Byte-by-byte reference: each access byte k lives at address addr+k.
  function automatic vec_t model(input vec_t v);
    vec_t        e;
    int          nbytes;
    int          pos;
    logic [31:0] base;
    logic [31:0] ba;
    logic [31:0] val;
    logic [7:0]  byt;
    e      = v;
    nbytes = 1 << v.size;
    e.s0 = '0; e.s1 = '0; e.w0 = '0; e.w1 = '0; e.data = '0; e.err = 1'b0;
    base = v.addr & ~32'h3;
    e.a0 = base;
    e.a1 = base + 32'd4;
    if (v.size == 2'd3) begin
      e.nb  = 0;
      e.err = 1'b1;
      return e;
    end
    e.nb = 1;
    val  = '0;
    for (int k = 0; k < nbytes; k++) begin
      ba = v.addr + 32'(k);
      if ((ba & ~32'h3) == base) begin
        e.s0[ba[1:0]] = 1'b1;
        byt = v.rd0[8*ba[1:0] +: 8];
      end else begin
        e.nb = 2;
        e.s1[ba[1:0]] = 1'b1;
        byt = v.rd1[8*ba[1:0] +: 8];
      end
      val[8*k +: 8] = byt;
    end
    // Whole store word moves up by the byte offset across the two beats.
    for (int k = 0; k < 4; k++) begin
      pos = int'(v.addr[1:0]) + k;
      if (pos < 4) e.w0[8*pos +: 8] = v.wdata[8*k +: 8];
      else         e.w1[8*(pos-4) +: 8] = v.wdata[8*k +: 8];
    end
    if (v.sig && val[8*nbytes-1]) begin
      for (int k = nbytes; k < 4; k++) val[8*k +: 8] = 8'hFF;
    end
    e.data = v.we ? 32'h0 : val;
    return e;
  endfunction

  // Observations from one transaction on the main instance
  int          ob_nb, ob_rsp_cyc;
  logic        ob_done, ob_stable, ob_busy_ready, ob_resp_ready, ob_err;
  logic        ob_post_rsp, ob_post_ready;
  logic [31:0] ob_a [2];
  logic [31:0] ob_w [2];
  logic [3:0]  ob_s [2];
  logic        ob_we [2];
  logic [31:0] ob_data;

  task automatic run_txn(input vec_t v, input int gdly, input int rdly);
    int phase;
    int wcnt;
    req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_sig = v.sig; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ob_nb = 0; ob_done = 1'b0; ob_stable = 1'b1; ob_busy_ready = 1'b0;
    ob_resp_ready = 1'b1; ob_err = 1'b0; ob_data = '0; ob_rsp_cyc = -1;
    ob_post_rsp = 1'b1; ob_post_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ob_a[i] = 'x; ob_w[i] = 'x; ob_s[i] = 'x; ob_we[i] = 1'bx;
    end
    phase = 0; wcnt = 0;
    for (int c = 0; c < 40; c++) begin
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
      if (rsp_valid) begin
        ob_done = 1'b1; ob_data = rsp_data; ob_err = rsp_err;
        ob_rsp_cyc = c; ob_resp_ready = req_ready;
        break;
      end
      if (req_ready) ob_busy_ready = 1'b1;
      if (phase == 0) begin
        if (bus_req) begin
          if (ob_nb < 2) begin
            if (wcnt == 0) begin
              ob_a[ob_nb] = bus_addr; ob_w[ob_nb] = bus_wdata;
              ob_s[ob_nb] = bus_wstrb; ob_we[ob_nb] = bus_we;
            end else if (bus_addr !== ob_a[ob_nb] || bus_wdata !== ob_w[ob_nb] ||
                         bus_wstrb !== ob_s[ob_nb] || bus_we !== ob_we[ob_nb]) begin
              ob_stable = 1'b0;
            end
          end
          if (wcnt >= gdly) begin
            bus_gnt = 1'b1; phase = 1; wcnt = 0;
          end else begin
            wcnt++;
          end
        end
      end else begin
        if (bus_req) ob_stable = 1'b0;
        if (wcnt >= rdly) begin
          bus_rvalid = 1'b1;
          bus_rdata  = (ob_nb == 0) ? v.rd0 : v.rd1;
          ob_nb++; phase = 0; wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      @(posedge clk); #1;
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    if (ob_done) begin
      @(posedge clk); #1;
      ob_post_rsp = rsp_valid; ob_post_ready = req_ready;
    end
  endtask

  task automatic check_txn(input string tag, input vec_t e);
    chk({tag, ".done"}, 64'(ob_done), 64'd1);
    chk({tag, ".beats"}, 64'(ob_nb), 64'(e.nb));
    if (e.nb >= 1) begin
      chk({tag, ".addr0"}, 64'(ob_a[0]), 64'(e.a0));
      chk({tag, ".strb0"}, 64'(ob_s[0]), 64'(e.s0));
      chk({tag, ".wdata0"}, 64'(ob_w[0]), 64'(e.w0));
      chk({tag, ".we0"}, 64'(ob_we[0]), 64'(e.we));
    end
    if (e.nb == 2) begin
      chk({tag, ".addr1"}, 64'(ob_a[1]), 64'(e.a1));
      chk({tag, ".strb1"}, 64'(ob_s[1]), 64'(e.s1));
      chk({tag, ".wdata1"}, 64'(ob_w[1]), 64'(e.w1));
      chk({tag, ".we1"}, 64'(ob_we[1]), 64'(e.we));
    end
    if (e.err) chk({tag, ".err_latency"}, 64'(ob_rsp_cyc), 64'd0);
    chk({tag, ".data"}, 64'(ob_data), 64'(e.data));
    chk({tag, ".err"}, 64'(ob_err), 64'(e.err));
    chk({tag, ".stable"}, 64'(ob_stable), 64'd1);
    chk({tag, ".busy_ready"}, 64'(ob_busy_ready | ob_resp_ready), 64'd0);
    chk({tag, ".pulse"}, 64'(ob_post_rsp), 64'd0);
    chk({tag, ".ready_after"}, 64'(ob_post_ready), 64'd1);
  endtask

  task automatic w_txn(input string tag, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [1:0] size, input logic sig,
                       input logic [63:0] rdata, input logic [63:0] e_addr,
                       input logic [7:0] e_strb, input logic [63:0] e_wdata,
                       input logic [63:0] e_data);
    w_req_we = we; w_req_addr = addr; w_req_wdata = wdata;
    w_req_size = size; w_req_sig = sig; w_req_valid = 1'b1;
    @(posedge clk); #1;
    w_req_valid = 1'b0;
    chk({tag, ".req"}, 64'(w_bus_req), 64'd1);
    chk({tag, ".addr"}, w_bus_addr, e_addr);
    chk({tag, ".strb"}, 64'(w_bus_wstrb), 64'(e_strb));
    chk({tag, ".wdata"}, w_bus_wdata, e_wdata);
    chk({tag, ".we"}, 64'(w_bus_we), 64'(we));
    w_bus_gnt = 1'b1;
    @(posedge clk); #1;
    w_bus_gnt = 1'b0; w_bus_rvalid = 1'b1; w_bus_rdata = rdata;
    @(posedge clk); #1;
    w_bus_rvalid = 1'b0;
    chk({tag, ".rsp_valid"}, 64'(w_rsp_valid), 64'd1);
    chk({tag, ".data"}, w_rsp_data, e_data);
    chk({tag, ".err"}, 64'(w_rsp_err), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic n_err_txn(input string tag, input logic [31:0] addr, input logic [1:0] size);
    n_req_we = 1'b0; n_req_addr = addr; n_req_wdata = '0;
    n_req_size = size; n_req_sig = 1'b0; n_req_valid = 1'b1;
    @(posedge clk); #1;
    n_req_valid = 1'b0;
    chk({tag, ".rsp_valid"}, 64'(n_rsp_valid), 64'd1);
    chk({tag, ".err"}, 64'(n_rsp_err), 64'd1);
    chk({tag, ".no_bus"}, 64'(n_bus_req), 64'd0);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 64'(n_rsp_valid), 64'd0);
    chk({tag, ".ready"}, 64'(n_req_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [11];
    vec_t v, e;
    int   r;
    logic saw;

    rst_n = 1'b0;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_sig = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    n_req_valid = 0; n_req_we = 0; n_req_addr = 0; n_req_wdata = 0; n_req_size = 0; n_req_sig = 0;
    n_bus_gnt = 0; n_bus_rvalid = 0; n_bus_rdata = 0;
    w_req_valid = 0; w_req_we = 0; w_req_addr = 0; w_req_wdata = 0; w_req_size = 0; w_req_sig = 0;
    w_bus_gnt = 0; w_bus_rvalid = 0; w_bus_rdata = 0;

    //             we  addr          wdata         sz sig rd0           rd1           nb a0            s0    w0            a1            s1    w1            data          err
    tbl[0]  = '{1'b0, 32'h00000100, 32'h00000000, 2'd2, 1'b0, 32'hDEADBEEF, 32'h00000000, 1, 32'h00000100, 4'hF, 32'h00000000, 32'h00000104, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[1]  = '{1'b1, 32'h00000203, 32'h000000AB, 2'd0, 1'b0, 32'h00000000, 32'h00000000, 1, 32'h00000200, 4'h8, 32'hAB000000, 32'h00000204, 4'h0, 32'h0, 32'h00000000, 1'b0};
    tbl[2]  = '{1'b0, 32'h00000007, 32'h00000000, 2'd1, 1'b0, 32'h80123456, 32'h12345601, 2, 32'h00000004, 4'h8, 32'h00000000, 32'h00000008, 4'h1, 32'h0, 32'h00000180, 1'b0};
    tbl[3]  = '{1'b0, 32'h00000007, 32'h00000000, 2'd1, 1'b1, 32'h80AABBCC, 32'h55667781, 2, 32'h00000004, 4'h8, 32'h00000000, 32'h00000008, 4'h1, 32'h0, 32'hFFFF8180, 1'b0};
    tbl[4]  = '{1'b1, 32'h00000010, 32'h00001234, 2'd3, 1'b0, 32'h00000000, 32'h00000000, 0, 32'h00000010, 4'h0, 32'h00000000, 32'h00000014, 4'h0, 32'h0, 32'h00000000, 1'b1};
    tbl[5]  = '{1'b0, 32'hFFFFFFFE, 32'h00000000, 2'd2, 1'b0, 32'hAABBCCDD, 32'h11223344, 2, 32'hFFFFFFFC, 4'hC, 32'h00000000, 32'h00000000, 4'h3, 32'h0, 32'h3344AABB, 1'b0};
    tbl[6]  = '{1'b1, 32'h00000002, 32'h00001234, 2'd1, 1'b0, 32'h00000000, 32'h00000000, 1, 32'h00000000, 4'hC, 32'h12340000, 32'h00000004, 4'h0, 32'h0, 32'h00000000, 1'b0};
    tbl[7]  = '{1'b0, 32'h00000001, 32'h00000000, 2'd0, 1'b1, 32'h0000F000, 32'h00000000, 1, 32'h00000000, 4'h2, 32'h00000000, 32'h00000004, 4'h0, 32'h0, 32'hFFFFFFF0, 1'b0};
    tbl[8]  = '{1'b1, 32'h00000005, 32'hCAFEF00D, 2'd2, 1'b0, 32'h00000000, 32'h00000000, 2, 32'h00000004, 4'hE, 32'hFEF00D00, 32'h00000008, 4'h1, 32'hCA, 32'h00000000, 1'b0};
    tbl[9]  = '{1'b0, 32'h00000003, 32'h00000000, 2'd0, 1'b0, 32'h80000000, 32'h00000000, 1, 32'h00000000, 4'h8, 32'h00000000, 32'h00000004, 4'h0, 32'h0, 32'h00000080, 1'b0};
    tbl[10] = '{1'b0, 32'h00000006, 32'h00000000, 2'd1, 1'b1, 32'h80017777, 32'h00000000, 1, 32'h00000004, 4'hC, 32'h00000000, 32'h00000008, 4'h0, 32'h0, 32'hFFFF8001, 1'b0};

    #12;
    chk("reset.ready", 64'(req_ready), 64'd1);
    chk("reset.bus_req", 64'(bus_req), 64'd0);
    chk("reset.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset.rsp_data", 64'(rsp_data), 64'd0);
    chk("reset.rsp_err", 64'(rsp_err), 64'd0);
    chk("reset.bus_lanes", 64'({bus_addr, bus_wdata}), 64'd0);
    chk("reset.bus_we_strb", 64'({bus_we, bus_wstrb}), 64'd0);
    chk("reset64.ready", 64'(w_req_ready), 64'd1);
    #8 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i], (i % 3 == 0) ? 0 : i % 3, 1 + (i % 2));
      check_txn($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset while the first beat is still requesting
    v = tbl[0];
    req_we = 1'b0; req_addr = 32'h40; req_size = 2'd2; req_sig = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_req0.pre_bus_req", 64'(bus_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req0.bus_req", 64'(bus_req), 64'd0);
    chk("rst_req0.ready", 64'(req_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while waiting for rvalid, then a stray rvalid
    req_addr = 32'h80; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    chk("rst_wait0.pre_ready", 64'(req_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait0.bus_req", 64'(bus_req), 64'd0);
    chk("rst_wait0.ready", 64'(req_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    saw = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
      if (rsp_valid) saw = 1'b1;
    end
    chk("rst_wait0.stray_rvalid", 64'(saw), 64'd0);
    chk("rst_wait0.ready_after", 64'(req_ready), 64'd1);

    // Random traffic against the byte-level model
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 15);
      v = tbl[0];
      v.we    = 1'($urandom_range(0, 1));
      v.size  = (r == 0) ? 2'd3 : 2'(r % 3);
      v.sig   = 1'($urandom_range(0, 1));
      v.addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : $urandom;
      v.wdata = $urandom;
      v.rd0   = $urandom;
      v.rd1   = $urandom;
      e = model(v);
      run_txn(v, $urandom_range(0, 2), $urandom_range(0, 2));
      check_txn($sformatf("rnd%0d", i), e);
    end

    // SPLIT=0: misaligned accesses error out with no bus traffic
    n_err_txn("ns_lw102", 32'h00000102, 2'd2);
    n_err_txn("ns_lh3", 32'h00000003, 2'd1);
    n_err_txn("ns_ld", 32'h00000008, 2'd3);
    n_req_we = 1'b0; n_req_addr = 32'h5; n_req_size = 2'd0; n_req_sig = 1'b0; n_req_valid = 1'b1;
    @(posedge clk); #1;
    n_req_valid = 1'b0;
    chk("ns_lb5.req", 64'(n_bus_req), 64'd1);
    chk("ns_lb5.addr", 64'(n_bus_addr), 64'h4);
    chk("ns_lb5.strb", 64'(n_bus_wstrb), 64'h2);
    n_bus_gnt = 1'b1;
    @(posedge clk); #1;
    n_bus_gnt = 1'b0; n_bus_rvalid = 1'b1; n_bus_rdata = 32'h0000AB00;
    @(posedge clk); #1;
    n_bus_rvalid = 1'b0;
    chk("ns_lb5.rsp_valid", 64'(n_rsp_valid), 64'd1);
    chk("ns_lb5.data", 64'(n_rsp_data), 64'hAB);
    chk("ns_lb5.err", 64'(n_rsp_err), 64'd0);
    @(posedge clk); #1;

    // XLEN=64 instance
    w_txn("x64_sd8", 1'b1, 64'h8, 64'h1122334455667788, 2'd3, 1'b0, 64'h0,
          64'h8, 8'hFF, 64'h1122334455667788, 64'h0);
    w_txn("x64_lw_c", 1'b0, 64'hC, 64'h0, 2'd2, 1'b1, 64'h80000000_12345678,
          64'h8, 8'hF0, 64'h0, 64'hFFFFFFFF80000000);
    w_txn("x64_ld10", 1'b0, 64'h10, 64'h0, 2'd3, 1'b1, 64'h8877665544332211,
          64'h10, 8'hFF, 64'h0, 64'h8877665544332211);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_split.md
Name: lsu_split

Overview:
- Parametrised load/store unit that generalises the core's combinational memory stage into a sequential block.
- Accepts one load/store request per transaction from the execute stage over a valid/ready handshake.
- Drives a req/gnt + rvalid data bus and returns sign/zero-extended load data.
- Optionally splits misaligned accesses into two aligned bus beats; otherwise flags them as errors. Enables multi-cycle memories and a stall-capable core.

Parameters:
- XLEN, 32, datapath width; 32 or 64.
- MISALIGNED_SPLIT, 1, 1 = split misaligned accesses into two beats; 0 = report o_rsp_err with no bus access.
- STRB_W, XLEN/8, byte-strobe width (derived, not overridable).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  core request valid
- o_req_ready  out  1  LSU can accept a request
- i_req_we  in  1  1 = store, 0 = load
- i_req_addr  in  XLEN  byte address
- i_req_wdata  in  XLEN  store data, LSB-justified
- i_req_size  in  2  0=B, 1=H, 2=W, 3=D
- i_req_sig  in  1  sign-extend load result
- o_rsp_valid  out  1  one-cycle completion pulse
- o_rsp_data  out  XLEN  extended load data; 0 for stores
- o_rsp_err  out  1  misaligned (SPLIT=0) or illegal size
- o_bus_req  out  1  bus request
- o_bus_addr  out  XLEN  aligned address (low log2(STRB_W) bits zero)
- o_bus_we  out  1  write enable
- o_bus_wdata  out  XLEN  store data shifted to byte lane
- o_bus_wstrb  out  STRB_W  byte strobes
- i_bus_gnt  in  1  request accepted
- i_bus_rvalid  in  1  beat complete; read data valid, or store ack
- i_bus_rdata  in  XLEN  read data

Behaviour:
- Reset: FSM=IDLE. o_req_ready=1. All other outputs 0. Captured registers cleared.
- Reset mid-transaction: immediate return to IDLE and o_bus_req dropped. Any later i_bus_rvalid is ignored.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- o_req_ready=1 only in IDLE.
- Accept on i_req_valid && o_req_ready. Capture we, addr, wdata, size, sig. Compute off = addr mod STRB_W and nbytes = 1<<size.
- Illegal: size==3 with XLEN=32. Misaligned: (addr mod nbytes) != 0.
- IDLE -> RESP with err=1 on illegal, or misaligned with SPLIT=0. No bus access occurs.
- Otherwise IDLE -> REQ0.
- split = (off + nbytes > STRB_W).
- REQ0: o_bus_req=1, addr = aligned(addr). Hold all bus outputs stable until i_bus_gnt, then go to WAIT0.
- WAIT0: wait for i_bus_rvalid, then go to REQ1 if split, else RESP.
- REQ1/WAIT1: same handshake at aligned(addr)+STRB_W.
- gnt and rvalid in the same cycle are not legal. rvalid arrives at least 1 cycle after gnt.
- Strobes: the full mask is ((1<<nbytes)-1) << off, STRB_W*2 bits wide.
  - Beat 0 uses the low STRB_W bits; beat 1 uses the high STRB_W bits.
  - wdata is shifted by off*8 into 2*XLEN and sliced the same way.
  - For loads, wstrb is still driven and used internally as the read mask.
- Load assembly: beat-0 rdata is registered into the low half, beat-1 into the high half. The combined value is shifted right by off*8, masked to nbytes, then sign- or zero-extended from bit nbytes*8-1.
- RESP: o_rsp_valid=1 for exactly one cycle, with o_rsp_data and o_rsp_err. Next cycle is IDLE (ready=1).
- Latency is fixed by the handshake; no additional cycles beyond that.
- At most one transaction outstanding. No back-to-back accept in the RESP cycle.
- Address wrap: aligned(addr)+STRB_W wraps modulo 2^XLEN.

Decomposition:
- Package lsu_pkg:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_D).
  - FSM state enum.
  - Function size_bytes(size).
- Sub-module lsu_align: combinational lane logic. Produces 2*STRB_W strobes, shifted 2*XLEN wdata, and extracted/extended load data from {hi,lo} rdata, off, size, and sig.
- lsu_split holds the FSM, the capture registers, and the beat registers.

Test Plan:
- XLEN=32. Aligned LW at 0x100, gnt on the 1st cycle, rvalid 2 cycles later with 0xDEADBEEF -> one bus beat: addr 0x100, wstrb 0xF, we=0. rsp_valid pulses with data 0xDEADBEEF, err=0.
- SB 0xAB at 0x203 -> bus addr 0x200, wstrb 0x8, wdata 0xAB000000. rsp_valid pulses, rsp_data=0.
- Signed LH at 0x7 with SPLIT=1; beat 0x4 rdata 0x80xxxxxx, beat 0x8 rdata 0xxxxxxx01 -> two beats with wstrb 0x8 then 0x1. rsp_data 0x00000180; with sig=1 and the high byte 0x81, data is 0xFFFF8180.
- SPLIT=0, LW at 0x102 -> no o_bus_req. rsp_valid with err=1 on the cycle after accept.
- XLEN=32, size=3 -> err=1 with no bus access. XLEN=64, SD at 0x8 -> one beat with wstrb 0xFF.
- Reset asserted during WAIT0 -> o_bus_req=0 and o_req_ready=1 immediately. A stray rvalid after reset causes no rsp_valid.
